muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Ports: clock, reset (async, active high); A/B operands, start+op request
//   (00 mult, 01 multu, 10 div, 11 divu), mthi/mtlo direct HI/LO writes;
//   busy, done pulse, divzero flag, HI/LO results.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         mthi,
    input  logic         mtlo,
    output logic         busy,
    output logic         done,
    output logic         divzero,
    output logic [N-1:0] HI,
    output logic [N-1:0] LO
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           neg_a;
    logic           neg_q;
    logic [N-1:0]   a_lat;
    logic [N-1:0]   mag_b;
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;

    // Operand magnitudes: only the signed ops (op[0]=0) look at sign bits.
    logic           sgn;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;

    assign sgn   = ~op[0];
    assign a_neg = sgn & A[N-1];
    assign b_neg = sgn & B[N-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // Shift-add step: acc_lo holds the remaining multiplier bits and
    // receives the low product bits as {acc_hi,acc_lo} shifts right.
    logic [N:0]     mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

    // Restoring step: acc_lo holds the dividend bits being shifted in and
    // collects quotient bits from the right.
    logic [N:0]     div_sh;
    logic           div_ge;
    logic [N-1:0]   div_dif;
    assign div_sh  = {acc_hi, acc_lo[N-1]};
    assign div_ge  = div_sh >= {1'b0, mag_b};
    assign div_dif = div_sh[N-1:0] - mag_b;

    // Sign correction applied on the FIX edge.
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   res_hi;
    logic [N-1:0]   res_lo;
    logic           dz;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        dz       = is_div & (mag_b == '0);
        res_hi   = prod_fix[2*N-1:N];
        res_lo   = prod_fix[N-1:0];
        if (is_div) begin
            res_lo = neg_q ? -acc_lo : acc_lo;
            res_hi = neg_a ? -acc_hi : acc_hi;
            if (dz) begin
                res_lo = '1;
                res_hi = a_lat;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_q   <= 1'b0;
            a_lat   <= '0;
            mag_b   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done    <= 1'b0;
                    divzero <= 1'b0;
                    if (start) begin
                        is_div <= op[1];
                        neg_a  <= a_neg;
                        neg_q  <= a_neg ^ b_neg;
                        a_lat  <= A;
                        mag_b  <= b_mag;
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        if (mthi) HI <= A;
                        if (mtlo) LO <= A;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_dif : div_sh[N-1:0];
                        acc_lo <= {acc_lo[N-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[N:1];
                        acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    HI      <= res_hi;
                    LO      <= res_lo;
                    divzero <= dz;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [N-1:0] HI;
    logic [N-1:0] LO;

    int compared = 0;
    int mismatched = 0;

    logic [N-1:0] hi_m = '0;
    logic [N-1:0] lo_m = '0;

    muldiv_unit #(.N(N)) dut (
        .clock(clock),
        .reset(reset),
        .A(A),
        .B(B),
        .start(start),
        .op(op),
        .mthi(mthi),
        .mtlo(mtlo),
        .busy(busy),
        .done(done),
        .divzero(divzero),
        .HI(HI),
        .LO(LO)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [N-1:0] a,
                                  input logic [N-1:0] b,
                                  output logic [N-1:0] h,
                                  output logic [N-1:0] l,
                                  output logic d);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d = 1'b0;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    d = 1'b1;
                    h = a;
                    l = '1;
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    // Called just after the start edge; follows the op to its done cycle.
    task automatic wait_res(input logic [N-1:0] eh, input logic [N-1:0] el,
                            input logic ed);
        bit bz, ea, dz0, hold;
        bz = 1; ea = 0; dz0 = 1; hold = 1;
        for (int e = 0; e <= N; e++) begin
            @(negedge clock);
            if (busy !== 1'b1) bz = 0;
            if (done !== 1'b0) ea = 1;
            if (divzero !== 1'b0) dz0 = 0;
            if (HI !== hi_m || LO !== lo_m) hold = 0;
            A = $urandom;
            B = $urandom;
            op = 2'($urandom);
            start = 1'($urandom);
            mthi = 1'($urandom);
            mtlo = 1'($urandom);
        end
        @(negedge clock);
        start = 0;
        mthi = 0;
        mtlo = 0;
        chk("busy_during_run", 64'(bz), 64'd1);
        chk("no_early_done", 64'(ea), 64'd0);
        chk("divzero_low_in_run", 64'(dz0), 64'd1);
        chk("hilo_held_in_run", 64'(hold), 64'd1);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("divzero", 64'(divzero), 64'(ed));
        chk("HI", 64'(HI), 64'(eh));
        chk("LO", 64'(LO), 64'(el));
        hi_m = eh;
        lo_m = el;
    endtask

    task automatic go(input logic [1:0] o, input logic [N-1:0] a,
                      input logic [N-1:0] b, input bit imm);
        logic [N-1:0] eh, el;
        logic         ed;
        if (!imm) @(negedge clock);
        A = a;
        B = b;
        op = o;
        start = 1;
        mthi = 1'($urandom);
        mtlo = 1'($urandom);
        @(posedge clock);
        #1;
        start = 0;
        mthi = 0;
        mtlo = 0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom);
        model(o, a, b, eh, el, ed);
        wait_res(eh, el, ed);
    endtask

    initial begin : stim
        int           dn;
        logic [N-1:0] ch, cl;
        logic [1:0]   o;
        logic [N-1:0] a, b;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divzero", 64'(divzero), 64'd0);
        chk("rst_HI", 64'(HI), 64'd0);
        chk("rst_LO", 64'(LO), 64'd0);
        reset = 0;

        go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        chk("multu_max_HI", 64'(HI), 64'hFFFFFFFE);
        chk("multu_max_LO", 64'(LO), 64'h00000001);

        go(2'b00, 32'hFFFFFFFD, 32'd5, 0);
        chk("mult_neg_HI", 64'(HI), 64'hFFFFFFFF);
        chk("mult_neg_LO", 64'(LO), 64'hFFFFFFF1);
        go(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_neg_LO", 64'(LO), 64'hFFFFFFFD);
        chk("div_neg_HI", 64'(HI), 64'hFFFFFFFF);

        go(2'b11, 32'd10, 32'd0, 0);
        chk("divz_LO", 64'(LO), 64'hFFFFFFFF);
        chk("divz_HI", 64'(HI), 64'h0000000A);
        chk("divz_flag", 64'(divzero), 64'd1);
        go(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_LO", 64'(LO), 64'h80000000);
        chk("ovf_HI", 64'(HI), 64'd0);
        chk("ovf_flag", 64'(divzero), 64'd0);

        go(2'b00, 32'h00012345, 32'hFFFF0F00, 0);
        go(2'b10, 32'hFFFF1234, 32'd77, 1);

        @(negedge clock);
        A = 32'd3;
        B = 32'd4;
        op = 2'b00;
        start = 1;
        @(posedge clock);
        #1;
        start = 0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_HI", 64'(HI), 64'd0);
        chk("midrst_LO", 64'(LO), 64'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clock);
        reset = 0;
        dn = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        go(2'b11, 32'd100, 32'd7, 0);
        chk("divu_100_7_LO", 64'(LO), 64'd14);
        chk("divu_100_7_HI", 64'(HI), 64'd2);

        @(negedge clock);
        A = 32'd6;
        B = 32'd7;
        op = 2'b01;
        start = 1;
        @(posedge clock);
        #1;
        start = 0;
        repeat (5) @(negedge clock);
        A = 32'h12345678;
        B = 32'd9;
        op = 2'b00;
        start = 1;
        mthi = 1;
        mtlo = 1;
        @(negedge clock);
        start = 0;
        mthi = 0;
        mtlo = 0;
        dn = 0;
        ch = '1;
        cl = '1;
        repeat (40) begin
            @(negedge clock);
            if (done) begin
                dn++;
                ch = HI;
                cl = LO;
            end
        end
        chk("busy_ign_pulses", 64'(dn), 64'd1);
        chk("busy_ign_HI", 64'(ch), 64'd0);
        chk("busy_ign_LO", 64'(cl), 64'd42);

        A = 32'h12345678;
        mthi = 1;
        mtlo = 1;
        @(negedge clock);
        mthi = 0;
        mtlo = 0;
        chk("mthilo_HI", 64'(HI), 64'h12345678);
        chk("mthilo_LO", 64'(LO), 64'h12345678);
        A = 32'hCAFEF00D;
        mthi = 1;
        @(negedge clock);
        mthi = 0;
        chk("mthi_HI", 64'(HI), 64'hCAFEF00D);
        chk("mthi_LO_hold", 64'(LO), 64'h12345678);
        hi_m = 32'hCAFEF00D;
        lo_m = 32'h12345678;

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin
                    a = 32'h80000000;
                    b = '1;
                end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            go(o, a, b, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
